uart_rx_deframer: RTL
=====================

Name: uart_rx_deframer

Overview:
- Receive-side deframer of the UART peripheral.
- Takes the raw RX line and recovers 8-bit characters using the programmed DIVIDER (clock cycles per bit). Checks the optional parity bit and the stop bit.
- Hands each character, with its error flags, to the RX FIFO over a valid/ready interface.
- Sits between the RX pad and the RX FIFO. Its flags feed the RXSTATUS and RXIRQMASK logic.

Parameters:
- DIV_W, 16, width of the divider input.
- DATA_BITS, 8, number of data bits per character (LSB first).

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_i  in  1  raw asynchronous RX line; idle level is 1.
- en_i  in  1  receive enable. Low when the mode is SIMPLEX/HALFDUPLEX with master=1, or when flush_rx=1.
- divider_i  in  DIV_W  clock cycles per bit; legal values are 4 or more.
- parity_en_i  in  1  a parity bit follows the data bits.
- parity_odd_i  in  1  1 = odd parity, 0 = even parity.
- data_o  out  DATA_BITS  received character.
- valid_o  out  1  data_o and the error flags are valid.
- ready_i  in  1  FIFO accepts the character (not fifo_full).
- parity_err_o  out  1  qualified by valid_o: parity mismatch on this character.
- framing_err_o  out  1  qualified by valid_o: stop bit sampled as 0.
- overrun_err_o  out  1  single-cycle pulse: a character was dropped.
- busy_o  out  1  state is not RX_IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state RX_IDLE. data_o=0, valid_o=0, all error outputs 0, busy_o=0. Synchronizer flops are set to 1. Counters are 0.
- Input path: rx_i passes through a 2-flop synchronizer to give rx_s. Fixed 2-cycle latency, included in every timing below.
- Bit counter: reloads to divider_i-1 and decrements to 0. Each expiry is a "sample point". divider_i is captured at the start edge and held for the whole character.
- RX_IDLE:
  - Requires en_i=1 and the line armed.
  - A 1->0 transition of rx_s loads the counter with (divider_i>>1)-1 and moves to RX_SHIFT (start check pending).
- Start check, at the first sample point:
  - rx_s=1: false start. Return to RX_IDLE; nothing is emitted.
  - rx_s=0: reload the counter with divider_i-1 and begin data sampling.
- RX_SHIFT:
  - At each sample point, shift rx_s into the shift register, LSB first.
  - After DATA_BITS samples, go to RX_PARITY if parity_en_i=1, otherwise to RX_STOP.
- RX_PARITY: at its sample point, compare rx_s with the computed parity.
  - Even: XOR of the data bits.
  - Odd: the inverse of that XOR.
  - A mismatch latches the parity error. Then go to RX_STOP.
- RX_STOP: at its sample point (mid stop bit):
  - rx_s=0 latches the framing error.
  - Emit the character on the next cycle, even if it has errors, and return to RX_IDLE.
  - The block is ready for a new start edge half a bit before the nominal stop end.
- Line arming:
  - After a framing error, the line is armed only once rx_s has been observed as 1 for at least one cycle. A break condition therefore yields exactly one character.
  - Otherwise the line is armed immediately.
- Output handshake:
  - valid_o rises 1 cycle after the stop sample point.
  - data_o and the error flags hold stable while valid_o=1 and ready_i=0.
  - Transfer happens on a cycle with valid_o=1 and ready_i=1; valid_o falls the next cycle unless a new character is emitted that same cycle.
  - Emit and accept in the same cycle: the new character replaces the old one, and valid_o stays 1.
- Overrun:
  - Triggered when a new character completes while valid_o=1 and ready_i=0.
  - The new character is discarded and the held one is kept.
  - overrun_err_o pulses for 1 cycle.
- en_i deasserted mid-character:
  - Abort immediately to RX_IDLE; the partial character is discarded.
  - An already-valid output is retained until it is accepted.
- en_i=0 in RX_IDLE: start edges are ignored.
- Divider rule: divider_i<4 is illegal and behaviour is unspecified. The bench constrains divider_i to 4 or more.
- Timing and stability:
  - Frame length in clocks = divider_i*(1+DATA_BITS+parity_en+1), minus half a bit of slack at the stop bit.
  - Sampling tolerance is ±(divider_i/2-2) cycles of accumulated drift.

Test Plan:
1. divider_i=16, no parity, ready_i=1, send 0xA5 with stop=1. Expected: valid_o is high for 1 cycle with data_o=0xA5 and no errors, 2+16*9.5+1 cycles after the start edge ±1.
2. parity_en=1, parity_odd=0, send 0x07 with parity bit 0 (wrong; correct is 1). Expected: data_o=0x07, parity_err_o=1. Resend with parity bit 1: parity_err_o=0.
3. Send 0x3C with stop=0, then hold the line at 0 for 3 bit times, then return to 1. Expected: exactly one character, 0x3C, with framing_err_o=1 and no further characters. A following 0x55 is received cleanly.
4. Hold ready_i=0 and send 0x11 then 0x22 back-to-back. Expected: data_o stays 0x11 with valid_o=1, and overrun_err_o pulses once at the end of the second frame. Then raise ready_i: valid_o drops next cycle and 0x22 is never presented.
5. Glitch: rx_i low for 3 cycles at divider_i=16. Expected: false start, no valid_o, busy_o returns to 0. Then deassert en_i at bit 4 of a frame: no output, state RX_IDLE.
6. Assert rst_n=0 mid-frame (bit 5), release, and send 0x81. Expected: all outputs 0 during reset, then 0x81 is received cleanly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: recovers UART characters from the raw RX line and hands them to the RX FIFO
//   clk, rst_n      : system clock, asynchronous active-low reset
//   rx_i            : raw asynchronous RX line (idle high)
//   en_i            : receive enable; dropping it aborts a character in flight
//   divider_i       : clock cycles per bit (>= 4), captured at each start edge
//   parity_en_i     : a parity bit follows the data bits
//   parity_odd_i    : 1 = odd parity, 0 = even parity
//   data_o/valid_o  : received character, valid/ready handshake with ready_i
//   parity_err_o    : parity mismatch on the presented character
//   framing_err_o   : stop bit sampled low on the presented character
//   overrun_err_o   : one-cycle pulse when a completed character is dropped
//   busy_o          : a character is being received
module uart_rx_deframer #(
  parameter int DIV_W     = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  input  logic                 en_i,
  input  logic [DIV_W-1:0]     divider_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 framing_err_o,
  output logic                 overrun_err_o,
  output logic                 busy_o
);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_PARITY, RX_STOP} state_t;
  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [BC_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 start_q, start_d, armed_q, armed_d, par_err_q, par_err_d;
  logic                 valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic                 rx_s, fall, sample, emit, stop_err;
  assign rx_s   = sync2_q;
  assign fall   = rx_prev_q & ~rx_s;
  assign sample = cnt_q == '0;
  always_comb begin
    sync1_d   = rx_i;
    sync2_d   = sync1_q;
    rx_prev_d = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    start_d   = start_q;
    par_err_d = par_err_q;
    // after a framing error the line stays disarmed until it is seen high
    armed_d   = armed_q | rx_s;
    data_d    = data_q;
    valid_d   = valid_q & ~ready_i;
    pe_d      = pe_q;
    fe_d      = fe_q;
    ov_d      = 1'b0;
    emit      = 1'b0;
    stop_err  = 1'b0;
    if (!en_i) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (armed_q && fall) begin
            // first sample lands mid start bit
            cnt_d     = (divider_i >> 1) - 1'b1;
            div_d     = divider_i;
            bit_d     = '0;
            start_d   = 1'b1;
            par_err_d = 1'b0;
            state_d   = RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          if (!sample) begin
            cnt_d = cnt_q - 1'b1;
          end else if (start_q) begin
            state_d = rx_s ? RX_IDLE : RX_SHIFT;
            cnt_d   = div_q - 1'b1;
            start_d = 1'b0;
          end else begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            cnt_d   = div_q - 1'b1;
            if (bit_q == BC_W'(DATA_BITS - 1))
              state_d = parity_en_i ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (!sample) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            par_err_d = rx_s ^ (^shift_q) ^ parity_odd_i;
            cnt_d     = div_q - 1'b1;
            state_d   = RX_STOP;
          end
        end
        RX_STOP: begin
          if (!sample) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            emit     = 1'b1;
            stop_err = ~rx_s;
            armed_d  = rx_s;
            state_d  = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
    if (emit) begin
      if (valid_q && !ready_i) begin
        ov_d = 1'b1;
      end else begin
        data_d  = shift_q;
        pe_d    = par_err_q;
        fe_d    = stop_err;
        valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      start_q   <= 1'b0;
      armed_q   <= 1'b1;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      rx_prev_q <= rx_prev_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      start_q   <= start_d;
      armed_q   <= armed_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign parity_err_o  = pe_q;
  assign framing_err_o = fe_q;
  assign overrun_err_o = ov_q;
  assign busy_o        = state_q != RX_IDLE;
endmodule
